// File: rtl/ysyx_040750_wbu_if.sv
// Writeback unit bus bundle: ALU/LSU result beats, issue tracking,
// operand busy lookups and the registered GPR write port.
interface ysyx_040750_wbu_if #(
    parameter int XLEN = 64
);
    logic            I_alu_valid;
    logic            O_alu_ready;
    logic [4:0]      I_alu_rd;
    logic            I_alu_wen;
    logic [XLEN-1:0] I_alu_data;

    logic            I_lsu_valid;
    logic            O_lsu_ready;
    logic [4:0]      I_lsu_rd;
    logic [XLEN-1:0] I_lsu_data;
    logic [1:0]      I_lsu_size;
    logic            I_lsu_unsigned;
    logic [2:0]      I_lsu_offset;

    logic            I_issue_valid;
    logic [4:0]      I_issue_rd;
    logic [4:0]      I_rs1_addr;
    logic [4:0]      I_rs2_addr;
    logic            O_rs1_busy;
    logic            O_rs2_busy;

    logic            O_wen;
    logic [4:0]      O_rd_addr;
    logic [XLEN-1:0] O_wr_data;

    modport slave (
        input  I_alu_valid, I_alu_rd, I_alu_wen, I_alu_data,
        output O_alu_ready,
        input  I_lsu_valid, I_lsu_rd, I_lsu_data, I_lsu_size,
        input  I_lsu_unsigned, I_lsu_offset,
        output O_lsu_ready,
        input  I_issue_valid, I_issue_rd, I_rs1_addr, I_rs2_addr,
        output O_rs1_busy, O_rs2_busy,
        output O_wen, O_rd_addr, O_wr_data
    );

    modport master (
        output I_alu_valid, I_alu_rd, I_alu_wen, I_alu_data,
        input  O_alu_ready,
        output I_lsu_valid, I_lsu_rd, I_lsu_data, I_lsu_size,
        output I_lsu_unsigned, I_lsu_offset,
        input  O_lsu_ready,
        output I_issue_valid, I_issue_rd, I_rs1_addr, I_rs2_addr,
        input  O_rs1_busy, O_rs2_busy,
        input  O_wen, O_rd_addr, O_wr_data
    );
endinterface

// File: rtl/ysyx_040750_wbu.sv
// Writeback unit: LSU-priority arbitration, load lane select/extension,
// registered GPR write port and per-register pending-writeback scoreboard.
module ysyx_040750_wbu #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input logic                 I_sys_clk,
    input logic                 I_rst,
    ysyx_040750_wbu_if.slave    bus
);
    logic            wen_q, wen_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [NREG-1:0] busy_q, busy_d;

    logic            lsu_fire;
    logic            alu_fire;
    logic [XLEN-1:0] ld_sh;
    logic [XLEN-1:0] ld_val;

    assign bus.O_lsu_ready = 1'b1;
    assign bus.O_alu_ready = ~bus.I_lsu_valid;

    assign lsu_fire = bus.I_lsu_valid & ~I_rst;
    assign alu_fire = bus.I_alu_valid & ~bus.I_lsu_valid & ~I_rst;

    // Lane is aligned to size, so low offset bits below the size are dropped.
    always_comb begin
        ld_sh  = bus.I_lsu_data;
        ld_val = bus.I_lsu_data;
        unique case (bus.I_lsu_size)
            2'd0: begin
                ld_sh  = bus.I_lsu_data >> {bus.I_lsu_offset, 3'b000};
                ld_val = bus.I_lsu_unsigned
                       ? {{(XLEN-8){1'b0}}, ld_sh[7:0]}
                       : {{(XLEN-8){ld_sh[7]}}, ld_sh[7:0]};
            end
            2'd1: begin
                ld_sh  = bus.I_lsu_data >> {bus.I_lsu_offset[2:1], 4'b0000};
                ld_val = bus.I_lsu_unsigned
                       ? {{(XLEN-16){1'b0}}, ld_sh[15:0]}
                       : {{(XLEN-16){ld_sh[15]}}, ld_sh[15:0]};
            end
            2'd2: begin
                ld_sh  = bus.I_lsu_data >> {bus.I_lsu_offset[2], 5'b00000};
                ld_val = bus.I_lsu_unsigned
                       ? {{(XLEN-32){1'b0}}, ld_sh[31:0]}
                       : {{(XLEN-32){ld_sh[31]}}, ld_sh[31:0]};
            end
            2'd3: begin
                ld_sh  = bus.I_lsu_data;
                ld_val = bus.I_lsu_data;
            end
        endcase
    end

    always_comb begin
        wen_d  = 1'b0;
        rd_d   = rd_q;
        data_d = data_q;
        if (lsu_fire) begin
            wen_d = (bus.I_lsu_rd != 5'd0);
            if (wen_d) begin
                rd_d   = bus.I_lsu_rd;
                data_d = ld_val;
            end
        end else if (alu_fire) begin
            wen_d = bus.I_alu_wen & (bus.I_alu_rd != 5'd0);
            if (wen_d) begin
                rd_d   = bus.I_alu_rd;
                data_d = bus.I_alu_data;
            end
        end
    end

    // Clear before set so a new producer issued on the commit edge wins.
    always_comb begin
        busy_d = busy_q;
        if (wen_q)
            busy_d[rd_q] = 1'b0;
        if (bus.I_issue_valid && bus.I_issue_rd != 5'd0)
            busy_d[bus.I_issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            wen_q  <= 1'b0;
            rd_q   <= 5'd0;
            data_q <= '0;
            busy_q <= '0;
        end else begin
            wen_q  <= wen_d;
            rd_q   <= rd_d;
            data_q <= data_d;
            busy_q <= busy_d;
        end
    end

    assign bus.O_wen      = wen_q;
    assign bus.O_rd_addr  = rd_q;
    assign bus.O_wr_data  = data_q;
    assign bus.O_rs1_busy = busy_q[bus.I_rs1_addr];
    assign bus.O_rs2_busy = busy_q[bus.I_rs2_addr];
endmodule

// File: tb/tb_ysyx_040750_wbu.sv
// Scoreboard bench for the writeback unit: directed beats push expected
// GPR writes, a negedge monitor pops and compares every O_wen pulse.
module tb_ysyx_040750_wbu;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } wr_t;

    wr_t exp_q[$];

    ysyx_040750_wbu_if #(.XLEN(64)) bus ();

    ysyx_040750_wbu #(.XLEN(64), .NREG(32)) dut (
        .I_sys_clk (clk),
        .I_rst     (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [4:0] rd, input logic w,
                       input logic [63:0] d);
        bus.I_alu_valid = 1'b1;
        bus.I_alu_rd    = rd;
        bus.I_alu_wen   = w;
        bus.I_alu_data  = d;
    endtask

    task automatic lsu(input logic [4:0] rd, input logic [1:0] sz,
                       input logic u, input logic [2:0] off,
                       input logic [63:0] d);
        bus.I_lsu_valid    = 1'b1;
        bus.I_lsu_rd       = rd;
        bus.I_lsu_size     = sz;
        bus.I_lsu_unsigned = u;
        bus.I_lsu_offset   = off;
        bus.I_lsu_data     = d;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [63:0] d);
        wr_t e;
        e.rd   = rd;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus.O_wen === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wen actual rd=%0d data=%h required none",
                             bus.O_rd_addr, bus.O_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_rd", {59'd0, bus.O_rd_addr}, {59'd0, e.rd});
                    chk("wr_data", bus.O_wr_data, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    localparam logic [63:0] LD = 64'h8877665544332211;

    initial begin
        rst = 1'b1;
        bus.I_alu_valid = 1'b0; bus.I_alu_rd = '0;
        bus.I_alu_wen = 1'b0;   bus.I_alu_data = '0;
        bus.I_lsu_valid = 1'b0; bus.I_lsu_rd = '0;
        bus.I_lsu_data = '0;    bus.I_lsu_size = '0;
        bus.I_lsu_unsigned = 1'b0; bus.I_lsu_offset = '0;
        bus.I_issue_valid = 1'b0; bus.I_issue_rd = '0;
        bus.I_rs1_addr = '0;    bus.I_rs2_addr = '0;

        // Beat offered during reset must be dropped.
        alu(5'd7, 1'b1, 64'hDEAD);
        step();
        step();
        @(negedge clk);
        chk("rst_wen", {63'd0, bus.O_wen}, 64'd0);
        chk("rst_rd", {59'd0, bus.O_rd_addr}, 64'd0);
        chk("rst_data", bus.O_wr_data, 64'd0);
        step();
        rst = 1'b0;
        bus.I_alu_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.I_rs1_addr = i[4:0];
            #1;
            chk("rst_busy", {63'd0, bus.O_rs1_busy}, 64'd0);
        end
        chk("lsu_ready", {63'd0, bus.O_lsu_ready}, 64'd1);
        step();
        @(negedge clk);
        chk("rst_drop_wen", {63'd0, bus.O_wen}, 64'd0);

        // ALU write with busy tracking.
        step();
        bus.I_issue_valid = 1'b1; bus.I_issue_rd = 5'd5;
        bus.I_rs1_addr = 5'd5;
        step();
        bus.I_issue_valid = 1'b0;
        alu(5'd5, 1'b1, 64'h1234);
        expect_wr(5'd5, 64'h1234);
        @(negedge clk);
        chk("alu_ready", {63'd0, bus.O_alu_ready}, 64'd1);
        chk("busy5_pend", {63'd0, bus.O_rs1_busy}, 64'd1);
        step();
        bus.I_alu_valid = 1'b0;
        @(negedge clk);
        chk("busy5_wen", {63'd0, bus.O_rs1_busy}, 64'd1);
        step();
        @(negedge clk);
        chk("busy5_clr", {63'd0, bus.O_rs1_busy}, 64'd0);
        chk("wen_pulse", {63'd0, bus.O_wen}, 64'd0);
        chk("hold_rd", {59'd0, bus.O_rd_addr}, 64'd5);
        chk("hold_data", bus.O_wr_data, 64'h1234);

        // Conflict: LSU first, ALU held.
        step();
        alu(5'd3, 1'b1, 64'h33);
        lsu(5'd4, 2'd3, 1'b1, 3'd5, 64'h0123456789ABCDEF);
        expect_wr(5'd4, 64'h0123456789ABCDEF);
        expect_wr(5'd3, 64'h33);
        @(negedge clk);
        chk("conf_alu_ready", {63'd0, bus.O_alu_ready}, 64'd0);
        step();
        bus.I_lsu_valid = 1'b0;
        @(negedge clk);
        chk("held_alu_ready", {63'd0, bus.O_alu_ready}, 64'd1);
        step();
        bus.I_alu_valid = 1'b0;
        step();

        // Load formatting, back to back.
        lsu(5'd10, 2'd0, 1'b0, 3'd7, LD); expect_wr(5'd10, 64'hFFFFFFFFFFFFFF88);
        step();
        lsu(5'd11, 2'd1, 1'b1, 3'd6, LD); expect_wr(5'd11, 64'h0000000000008877);
        step();
        lsu(5'd12, 2'd2, 1'b0, 3'd4, LD); expect_wr(5'd12, 64'hFFFFFFFF88776655);
        step();
        lsu(5'd13, 2'd1, 1'b0, 3'd5, LD); expect_wr(5'd13, 64'h0000000000006655);
        step();
        lsu(5'd14, 2'd3, 1'b1, 3'd3, LD); expect_wr(5'd14, LD);
        step();
        lsu(5'd15, 2'd0, 1'b1, 3'd0, LD); expect_wr(5'd15, 64'h11);
        step();
        lsu(5'd16, 2'd2, 1'b1, 3'd7, LD); expect_wr(5'd16, 64'h0000000088776655);
        step();
        lsu(5'd17, 2'd1, 1'b0, 3'd7, LD); expect_wr(5'd17, 64'hFFFFFFFFFFFF8877);
        step();
        bus.I_lsu_valid = 1'b0;
        step();

        // Suppressed writes still handshake.
        alu(5'd0, 1'b1, 64'hFFFF);
        @(negedge clk);
        chk("rd0_ready", {63'd0, bus.O_alu_ready}, 64'd1);
        step();
        alu(5'd6, 1'b0, 64'h1);
        step();
        bus.I_alu_valid = 1'b0;
        @(negedge clk);
        chk("nowen_wen", {63'd0, bus.O_wen}, 64'd0);
        bus.I_issue_valid = 1'b1; bus.I_issue_rd = 5'd0;
        step();
        bus.I_issue_valid = 1'b0;
        bus.I_rs1_addr = 5'd0; bus.I_rs2_addr = 5'd6;
        @(negedge clk);
        chk("busy0", {63'd0, bus.O_rs1_busy}, 64'd0);
        chk("busy6", {63'd0, bus.O_rs2_busy}, 64'd0);

        // Set/clear collision on rd=9.
        step();
        bus.I_issue_valid = 1'b1; bus.I_issue_rd = 5'd9;
        bus.I_rs2_addr = 5'd9;
        step();
        bus.I_issue_valid = 1'b0;
        alu(5'd9, 1'b1, 64'h99); expect_wr(5'd9, 64'h99);
        step();
        bus.I_alu_valid = 1'b0;
        bus.I_issue_valid = 1'b1; bus.I_issue_rd = 5'd9;
        @(negedge clk);
        chk("coll_busy_before", {63'd0, bus.O_rs2_busy}, 64'd1);
        step();
        bus.I_issue_valid = 1'b0;
        @(negedge clk);
        chk("coll_busy_after", {63'd0, bus.O_rs2_busy}, 64'd1);
        step();
        alu(5'd9, 1'b1, 64'h999); expect_wr(5'd9, 64'h999);
        step();
        bus.I_alu_valid = 1'b0;
        step();
        @(negedge clk);
        chk("coll_busy_clr", {63'd0, bus.O_rs2_busy}, 64'd0);

        // Reset mid-operation discards busy and the pending beat.
        step();
        bus.I_issue_valid = 1'b1; bus.I_issue_rd = 5'd8;
        bus.I_rs1_addr = 5'd8;
        step();
        bus.I_issue_valid = 1'b0;
        @(negedge clk);
        chk("busy8_set", {63'd0, bus.O_rs1_busy}, 64'd1);
        step();
        alu(5'd8, 1'b1, 64'h88);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.I_alu_valid = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {63'd0, bus.O_rs1_busy}, 64'd0);
        chk("midrst_wen", {63'd0, bus.O_wen}, 64'd0);
        chk("midrst_rd", {59'd0, bus.O_rd_addr}, 64'd0);

        step();
        step();
        step();
        chk("drain", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_040750_wbu.md
Name: ysyx_040750_wbu

Overview:
Writeback unit that drives the GPR write port (wen / rd_addr / wr_data) of the register file. It arbitrates between single-cycle ALU results and load responses from the LSU, aligns and sign/zero-extends load data, and registers the write. It also keeps a per-register busy scoreboard, so issue logic can stall on operands whose writeback is still pending.

Parameters:
XLEN, 64, datapath width; fixed at 64 for this core.
NREG, 32, number of architectural GPRs; rd/rs index width is 5.

Ports:
I_sys_clk  input  1  core clock
I_rst  input  1  synchronous reset, active-high
I_alu_valid  input  1  ALU result beat valid
O_alu_ready  output  1  ALU beat accepted this cycle when valid&ready
I_alu_rd  input  5  ALU destination register
I_alu_wen  input  1  ALU instruction writes rd
I_alu_data  input  64  ALU result
I_lsu_valid  input  1  load response valid
O_lsu_ready  output  1  load beat accepted; tied high
I_lsu_rd  input  5  load destination register
I_lsu_data  input  64  raw 64-bit aligned memory word
I_lsu_size  input  2  0=byte, 1=half, 2=word, 3=double
I_lsu_unsigned  input  1  1=zero-extend, 0=sign-extend
I_lsu_offset  input  3  byte address bits [2:0]
I_issue_valid  input  1  an instruction with rd write issues this cycle
I_issue_rd  input  5  its destination register
I_rs1_addr  input  5  source register 1 being checked
I_rs2_addr  input  5  source register 2 being checked
O_rs1_busy  output  1  rs1 has a pending writeback
O_rs2_busy  output  1  rs2 has a pending writeback
O_wen  output  1  GPR write enable (registered)
O_rd_addr  output  5  GPR write address (registered)
O_wr_data  output  64  GPR write data (registered)

Behaviour:
- Reset: I_rst, clock I_sys_clk; synchronous, active-high. O_wen=0, O_rd_addr=0, O_wr_data=0, all busy bits=0. A beat presented during reset is dropped, not accepted.
- Arbitration: the LSU has priority.
  - O_lsu_ready=1 always.
  - O_alu_ready = ~I_lsu_valid, combinational.
  - An ALU beat stalled by an LSU beat must hold its payload stable until accepted.
- Latency: a beat accepted at edge N appears on O_wen/O_rd_addr/O_wr_data during cycle N+1. The GPR commits it at edge N+1. O_wen is a one-cycle pulse per beat.
- Cycle with no accepted beat: O_wen=0; O_rd_addr and O_wr_data hold their previous values.
- Write suppression: O_wen=0 when rd==0 or, for an ALU beat, when I_alu_wen==0. Such a beat is still accepted (handshake completes).
- Load formatting:
  - Lane select: lanes are aligned to size; offset bits below the size alignment are ignored.
  - byte: data[8*off +: 8].
  - half: data[16*off[2:1] +: 16].
  - word: data[32*off[2] +: 32].
  - double: full word, offset ignored.
  - Extension to 64 bits: zero if I_lsu_unsigned, else sign extend. Double is unaffected by I_lsu_unsigned.
- Scoreboard: 32 busy bits; bit 0 is hardwired 0.
  - Set: at an edge where I_issue_valid and I_issue_rd!=0.
  - Clear: at the edge ending a cycle where O_wen=1, for bit O_rd_addr.
  - Same rd set and cleared on the same edge: set wins (newer producer).
  - A pending writeback suppressed by wen=0 does not clear any bit; issue must not set a bit for non-writing instructions.
- O_rsX_busy = busy[rsX], combinational.
  - No bypass: busy stays 1 during the O_wen cycle.
  - busy reads 0 in the following cycle, when the GPR already holds the data.
- Only one pending producer per rd is supported. A second issue to an already-busy rd is upstream's responsibility (stall) and is not checked.
- Reset mid-operation: the held ALU beat and all busy bits are discarded; the O_wen pulse is forced to 0 on the reset edge.

Test Plan:
- Reset then idle: O_wen=0, O_rd_addr=0, O_wr_data=0, all busy=0; an ALU beat with alu_valid=1 during I_rst=1 produces no O_wen afterwards.
- ALU write: issue rd=5; next cycle alu_valid, rd=5, data=0x1234 -> next cycle O_wen=1, O_rd_addr=5, O_wr_data=0x1234; rs1=5 busy=1 through that cycle, 0 the cycle after.
- Conflict: alu_valid rd=3 and lsu_valid rd=4 in the same cycle -> O_alu_ready=0; write rd=4 first, then rd=3 the next cycle; the ALU beat is held without loss.
- Load extension: data=0x8877665544332211.
  - off=7, byte, signed -> 0xFFFFFFFFFFFFFF88.
  - off=6, half, unsigned -> 0x0000000000008877.
  - off=4, word, signed -> 0xFFFFFFFF88776655.
  - off=5, half -> same lane as off=4 (0x6655, sign-extended 0x0000000000006655).
- rd=0 / wen=0: ALU beat rd=0 data=0xFFFF -> handshake completes, O_wen=0; issue rd=0 -> busy never set.
- Set/clear collision: O_wen for rd=9 in the same cycle as issue rd=9 -> busy[9] stays 1 after the edge.
